// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master arbiter in front of a single-ported data RAM.
// m0 is the CPU MEM stage (fixed priority), m1 is the debug/DMA port.
// m1 is guaranteed a slot after STARVE_LIMIT back-to-back m0 grants.
// Optional macro DRAM_ARB_PERF_EN adds grant and stall performance counters.
module dram_arbiter #(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        stallreq,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [31:0] m0_grant_cnt,
  output logic [31:0] m1_grant_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  starve_q, starve_d;
  logic        winner_q, winner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        grant;
  logic        grant_m1;

  // Arbitration: m0 wins unless m1 has been starved up to the limit.
  always_comb begin
    grant    = (state_q == IDLE) && (m0_req || m1_req);
    grant_m1 = m1_req && (!m0_req || (starve_q == STARVE_MAX));
  end

  // Next-state logic: one access phase of WAIT_CYCLES, then a single ack cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q <= 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: latch the winner's request, count access cycles, capture read data.
  always_comb begin
    wait_d     = wait_q;
    winner_d   = winner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    if (grant) begin
      winner_d = grant_m1;
      wait_d   = WAIT_LOAD;
      if (grant_m1) begin
        we_d    = m1_we;
        addr_d  = m1_addr;
        sel_d   = m1_sel;
        wdata_d = m1_wdata;
      end else begin
        we_d    = m0_we;
        addr_d  = m0_addr;
        sel_d   = m0_sel;
        wdata_d = m0_wdata;
      end
    end

    if (state_q == ACCESS) begin
      if (wait_q != 4'd0) begin
        wait_d = wait_q - 4'd1;
      end
      if ((wait_q <= 4'd1) && !we_q) begin
        if (winner_q) begin
          m1_rdata_d = ram_data_i;
        end else begin
          m0_rdata_d = ram_data_i;
        end
      end
    end
  end

  // Starvation tracking: count m0 grants that bypass a waiting m1.
  always_comb begin
    starve_d = starve_q;
    if (!m1_req) begin
      starve_d = 4'd0;
    end else if (grant && grant_m1) begin
      starve_d = 4'd0;
    end else if (grant) begin
      if (starve_q < STARVE_MAX) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Outputs: RAM strobes only during ACCESS, ack only during DONE.
  always_comb begin
    ram_ce     = (state_q == ACCESS);
    ram_we     = (state_q == ACCESS) && we_q;
    ram_addr   = addr_q;
    ram_sel    = sel_q;
    ram_data_o = wdata_q;
    m0_ack     = (state_q == DONE) && !winner_q;
    m1_ack     = (state_q == DONE) && winner_q;
    m0_rdata   = m0_rdata_q;
    m1_rdata   = m1_rdata_q;
    stallreq   = m0_req && !m0_ack;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_q     <= 4'd0;
      starve_q   <= 4'd0;
      winner_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      winner_q   <= winner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] m0_grant_cnt_q, m0_grant_cnt_d;
  logic [31:0] m1_grant_cnt_q, m1_grant_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Performance counters: free-running, wrap naturally at 2^32.
  always_comb begin
    m0_grant_cnt_d = m0_grant_cnt_q + {31'd0, (grant && !grant_m1)};
    m1_grant_cnt_d = m1_grant_cnt_q + {31'd0, (grant && grant_m1)};
    stall_cnt_d    = stall_cnt_q + {31'd0, stallreq};
    m0_grant_cnt   = m0_grant_cnt_q;
    m1_grant_cnt   = m1_grant_cnt_q;
    stall_cnt      = stall_cnt_q;
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m0_grant_cnt_q <= 32'd0;
      m1_grant_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      m0_grant_cnt_q <= m0_grant_cnt_d;
      m1_grant_cnt_q <= m1_grant_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter.
// Instance dut uses WAIT_CYCLES=1, instance dut3 uses WAIT_CYCLES=3.
// Honours DRAM_ARB_PERF_EN to connect and check the performance counters.
module tb_dram_arbiter;

  localparam int W_A = 1;
  localparam int W_B = 3;

  logic clk = 1'b0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Signals for the WAIT_CYCLES=1 instance
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
  logic [3:0]  m0_sel = 4'd0;
  logic [31:0] m0_rdata;
  logic        m0_ack, stallreq;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
  logic [3:0]  m1_sel = 4'd0;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel;

  // Signals for the WAIT_CYCLES=3 instance
  logic        b_rst = 1'b0;
  logic        b_m0_req = 1'b0, b_m0_we = 1'b0;
  logic [31:0] b_m0_addr = 32'd0, b_m0_wdata = 32'd0;
  logic [3:0]  b_m0_sel = 4'd0;
  logic [31:0] b_m0_rdata;
  logic        b_m0_ack, b_stallreq;
  logic        b_m1_req = 1'b0, b_m1_we = 1'b0;
  logic [31:0] b_m1_addr = 32'd0, b_m1_wdata = 32'd0;
  logic [3:0]  b_m1_sel = 4'd0;
  logic [31:0] b_m1_rdata;
  logic        b_m1_ack;
  logic        b_ram_ce, b_ram_we;
  logic [31:0] b_ram_addr, b_ram_data_o, b_ram_data_i;
  logic [3:0]  b_ram_sel;

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] m0_grant_cnt, m1_grant_cnt, stall_cnt;
  logic [31:0] b_m0_grant_cnt, b_m1_grant_cnt, b_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  dram_arbiter #(.WAIT_CYCLES(W_A), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .stallreq(stallreq),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
`ifdef DRAM_ARB_PERF_EN
    ,
    .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  dram_arbiter #(.WAIT_CYCLES(W_B), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(b_rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_sel(b_m0_sel),
    .m0_wdata(b_m0_wdata), .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .stallreq(b_stallreq),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_sel(b_m1_sel),
    .m1_wdata(b_m1_wdata), .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_sel(b_ram_sel),
    .ram_data_o(b_ram_data_o), .ram_data_i(b_ram_data_i)
`ifdef DRAM_ARB_PERF_EN
    ,
    .m0_grant_cnt(b_m0_grant_cnt), .m1_grant_cnt(b_m1_grant_cnt), .stall_cnt(b_stall_cnt)
`endif
  );

  // Asynchronous-read RAM models, word indexed by address bits [5:2].
  assign ram_data_i   = mem_a[ram_addr[5:2]];
  assign b_ram_data_i = mem_b[b_ram_addr[5:2]];

  // Byte-enabled write into the model behind the WAIT_CYCLES=1 instance.
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_sel[i]) mem_a[ram_addr[5:2]][8*i +: 8] = ram_data_o[8*i +: 8];
      end
    end
  end

  exp_t        mon_e;
  logic [31:0] mon_rd;
  int          mon_port;

  // Scoreboard: every ack of the main instance is matched to the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (m0_ack || m1_ack) begin
      checks++;
      if (m0_ack && m1_ack) begin
        errors++;
        $display("[TB] FAIL sb_dual_ack m0_ack=%0b m1_ack=%0b required one", m0_ack, m1_ack);
      end else if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_ack m0_ack=%0b m1_ack=%0b required none", m0_ack, m1_ack);
      end else begin
        mon_e    = sb.pop_front();
        mon_port = m1_ack ? 1 : 0;
        mon_rd   = m1_ack ? m1_rdata : m0_rdata;
        if (mon_port != mon_e.port) begin
          errors++;
          $display("[TB] FAIL sb_grant_order got m%0d required m%0d", mon_port, mon_e.port);
        end else if (mon_e.is_read && (mon_rd !== mon_e.data)) begin
          errors++;
          $display("[TB] FAIL sb_rdata m%0d got %h required %h", mon_port, mon_rd, mon_e.data);
        end
      end
    end
  end

  // Drive one transaction on the main instance and report what was observed.
  task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic drop_early,
                         output int lat, output int ce_cycles, output int we_cycles,
                         output logic [31:0] seen_addr, output logic [3:0] seen_sel,
                         output logic [31:0] seen_wdata);
    exp_t e;
    @(negedge clk);
    if (port == 0) begin
      m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata; m1_req = 1'b1;
    end
    e.port = port; e.is_read = !we; e.data = exp_rdata;
    sb.push_back(e);
    lat = -1; ce_cycles = 0; we_cycles = 0;
    seen_addr = 32'd0; seen_sel = 4'd0; seen_wdata = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ram_ce) begin
        ce_cycles++;
        if (ram_we) we_cycles++;
        seen_addr = ram_addr; seen_sel = ram_sel; seen_wdata = ram_data_o;
      end
      if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) begin
        lat = k;
        break;
      end
      if (k == 1 && drop_early) begin
        if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
      end
    end
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Reset held with random request traffic: every output must be zero.
  task automatic test_reset();
    rst = 1'b0; b_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      m0_req = 1'($urandom); m1_req = 1'($urandom); m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      b_m0_req = 1'($urandom); b_m1_req = 1'($urandom); b_m0_we = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({ram_ce, ram_we, m0_ack, m1_ack, m0_rdata, m1_rdata, ram_addr, ram_sel, ram_data_o} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d ce=%b we=%b ack=%b%b rd0=%h rd1=%h addr=%h sel=%h wd=%h required all 0",
                 c, ram_ce, ram_we, m0_ack, m1_ack, m0_rdata, m1_rdata, ram_addr, ram_sel, ram_data_o);
      end
      checks++;
      if ({b_ram_ce, b_ram_we, b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_sel, b_ram_data_o} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs_w3 cycle %0d ce=%b ack=%b%b rd0=%h addr=%h required all 0",
                 c, b_ram_ce, b_m0_ack, b_m1_ack, b_m0_rdata, b_ram_addr);
      end
    end
`ifdef DRAM_ARB_PERF_EN
    checks++;
    if ({m0_grant_cnt, m1_grant_cnt, stall_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_perf got %0d %0d %0d required 0 0 0", m0_grant_cnt, m1_grant_cnt, stall_cnt);
    end
`endif
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    b_m0_req = 1'b0; b_m1_req = 1'b0; b_m0_we = 1'b0;
    rst = 1'b1; b_rst = 1'b1;
  endtask

  // Single m0 read with cycle-exact timing of ce, ack and stallreq.
  task automatic test_read();
    exp_t e;
    @(negedge clk);
    m0_we = 1'b0; m0_addr = 32'h0; m0_sel = 4'hF; m0_req = 1'b1;
    e.port = 0; e.is_read = 1'b1; e.data = 32'h00001234;
    sb.push_back(e);
    #1;
    checks++;
    if (stallreq !== 1'b1 || ram_ce !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_cycle0 stallreq=%b ce=%b required 1 0", stallreq, ram_ce);
    end
    @(posedge clk); #1;
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h0 || stallreq !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_cycle1 ce=%b we=%b addr=%h stall=%b ack=%b required 1 0 0 1 0",
               ram_ce, ram_we, ram_addr, stallreq, m0_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (m0_ack !== 1'b1 || ram_ce !== 1'b0 || stallreq !== 1'b0 || m0_rdata !== 32'h00001234) begin
      errors++;
      $display("[TB] FAIL read_ack ack=%b ce=%b stall=%b rdata=%h required 1 0 0 00001234",
               m0_ack, ram_ce, stallreq, m0_rdata);
    end
    @(negedge clk);
    m0_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m0_ack !== 1'b0 || ram_ce !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_ack_single ack=%b ce=%b required 0 0", m0_ack, ram_ce);
    end
  endtask

  // m0 write followed by an m1 read of the same word.
  task automatic test_write_read();
    int lat, cec, wec;
    logic [31:0] sa, sw;
    logic [3:0] ss;
    run_txn(0, 1'b1, 32'h4, 4'hF, 32'h000089AB, 32'h0, 1'b0, lat, cec, wec, sa, ss, sw);
    checks++;
    if (lat != W_A + 1 || cec != W_A || wec != 1 || sa !== 32'h4 || sw !== 32'h000089AB || mem_a[1] !== 32'h000089AB) begin
      errors++;
      $display("[TB] FAIL write_m0 lat=%0d ce=%0d we=%0d addr=%h wdata=%h mem=%h required 2 1 1 4 000089ab 000089ab",
               lat, cec, wec, sa, sw, mem_a[1]);
    end
    run_txn(1, 1'b0, 32'h4, 4'hF, 32'h0, 32'h000089AB, 1'b0, lat, cec, wec, sa, ss, sw);
    checks++;
    if (lat != W_A + 1 || cec != W_A || wec != 0 || m1_rdata !== 32'h000089AB) begin
      errors++;
      $display("[TB] FAIL read_m1 lat=%0d ce=%0d we=%0d rdata=%h required 2 1 0 000089ab", lat, cec, wec, m1_rdata);
    end
    checks++;
    if (m0_rdata !== 32'h00001234) begin
      errors++;
      $display("[TB] FAIL rdata_hold_m0 got %h required 00001234", m0_rdata);
    end
  endtask

  // Partial byte write: sel and data reach the RAM unmodified.
  task automatic test_byte_sel();
    int lat, cec, wec;
    logic [31:0] sa, sw;
    logic [3:0] ss;
    run_txn(0, 1'b1, 32'h8, 4'b0101, 32'hDEADBEEF, 32'h0, 1'b0, lat, cec, wec, sa, ss, sw);
    checks++;
    if (ss !== 4'b0101 || sw !== 32'hDEADBEEF || mem_a[2] !== 32'h00AD00EF) begin
      errors++;
      $display("[TB] FAIL byte_sel sel=%b wdata=%h mem=%h required 0101 deadbeef 00ad00ef", ss, sw, mem_a[2]);
    end
    run_txn(1, 1'b0, 32'h8, 4'hF, 32'h0, 32'h00AD00EF, 1'b0, lat, cec, wec, sa, ss, sw);
    checks++;
    if (lat != W_A + 1) begin
      errors++;
      $display("[TB] FAIL byte_sel_read_lat got %0d required %0d", lat, W_A + 1);
    end
  endtask

  // Request withdrawn right after the grant still completes with an ack.
  task automatic test_drop_early();
    int lat, cec, wec;
    logic [31:0] sa, sw;
    logic [3:0] ss;
    run_txn(0, 1'b0, 32'h4, 4'hF, 32'h0, 32'h000089AB, 1'b1, lat, cec, wec, sa, ss, sw);
    checks++;
    if (lat != W_A + 1 || cec != W_A) begin
      errors++;
      $display("[TB] FAIL drop_early lat=%0d ce=%0d required %0d %0d", lat, cec, W_A + 1, W_A);
    end
    checks++;
    if (m1_rdata !== 32'h00AD00EF) begin
      errors++;
      $display("[TB] FAIL rdata_hold_m1 got %h required 00ad00ef", m1_rdata);
    end
  endtask

  // Both masters requesting continuously: four m0 grants then one m1 grant.
  task automatic test_starvation();
    exp_t e;
    bool_done: begin end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m0_we = 1'b0; m0_addr = 32'h0; m0_sel = 4'hF;
    m1_we = 1'b0; m1_addr = 32'h4; m1_sel = 4'hF;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e.port    = ((i % 5) == 4) ? 1 : 0;
      e.is_read = 1'b1;
      e.data    = (e.port == 1) ? 32'h000089AB : 32'h00001234;
      sb.push_back(e);
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL starve_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
`ifdef DRAM_ARB_PERF_EN
    checks++;
    if (m0_grant_cnt !== 32'd8 || m1_grant_cnt !== 32'd2) begin
      errors++;
      $display("[TB] FAIL perf_grants m0=%0d m1=%0d required 8 2", m0_grant_cnt, m1_grant_cnt);
    end
`endif
  endtask

  // Reset in the second ACCESS cycle of a 3-cycle access abandons it silently.
  task automatic test_reset_in_access();
    int acks;
    int lat;
    @(negedge clk);
    b_m0_we = 1'b0; b_m0_addr = 32'h0; b_m0_sel = 4'hF; b_m0_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (b_ram_ce !== 1'b1 || b_m0_ack !== 1'b0 || b_stallreq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL w3_access2 ce=%b ack=%b stall=%b required 1 0 1", b_ram_ce, b_m0_ack, b_stallreq);
    end
    @(negedge clk);
    b_rst = 1'b0; b_m0_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b_ram_ce !== 1'b0 || b_m0_ack !== 1'b0 || b_m0_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL w3_reset_abort ce=%b ack=%b rdata=%h required 0 0 0", b_ram_ce, b_m0_ack, b_m0_rdata);
    end
    @(negedge clk);
    b_rst = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (b_m0_ack || b_m1_ack || b_ram_ce) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("[TB] FAIL w3_no_ack activity=%0d required 0", acks);
    end
    @(negedge clk);
    b_m0_addr = 32'h4; b_m0_req = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b_m0_ack) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
    b_m0_req = 1'b0;
    checks++;
    if (lat != W_B + 1 || b_m0_rdata !== 32'h00007777 || b_m1_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL w3_read_after_reset lat=%0d rdata=%h m1_rdata=%h required %0d 00007777 0",
               lat, b_m0_rdata, b_m1_rdata, W_B + 1);
    end
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'h00001234;
    mem_b[0] = 32'h00005555;
    mem_b[1] = 32'h00007777;
    test_reset();
    test_read();
    test_write_read();
    test_byte_sel();
    test_drop_early();
    test_starvation();
    test_reset_in_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
